// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the byte-wide SRAM bridge.
// Frame header layout, FSM states and the byte-mask expander.
package sram_bridge_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam logic [7:0] ACK_BYTE = 8'h5A;

  localparam int HDR_WR     = 7;
  localparam int HDR_BM_HI  = 6;
  localparam int HDR_BM_LO  = 3;
  localparam int HDR_AHI_HI = 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_ACK,
    S_READ,
    S_RWAIT,
    S_RSP
  } state_t;

  function automatic logic [DATA_W-1:0] bm_expand(
    input logic [3:0] m
  );
    return {{8{m[3]}}, {8{m[2]}},
            {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/sram_byte_bridge_if.sv
// Byte command and response channels between host and bridge.
// Both channels move a byte on valid && ready at a rising edge.
interface sram_byte_bridge_if;

  logic [7:0] cmd_data_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [7:0] rsp_data_o;
  logic       rsp_valid_o;
  logic       rsp_ready_i;

  modport slave (
    input  cmd_data_i,
    input  cmd_valid_i,
    output cmd_ready_o,
    output rsp_data_o,
    output rsp_valid_o,
    input  rsp_ready_i
  );

  modport master (
    output cmd_data_i,
    output cmd_valid_i,
    input  cmd_ready_o,
    input  rsp_data_o,
    input  rsp_valid_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/sram_bridge_rsp_ser.sv
// Response serializer: loads a word (or the ack byte) and
// emits it LSB first, holding each byte until it is taken.
module sram_bridge_rsp_ser
  import sram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        count,
  output logic [7:0]        data,
  output logic              valid,
  input  logic              ready,
  output logic              done
);

  logic [DATA_W-1:0] sh;
  logic [2:0]        left;

  assign data = sh[7:0];
  assign done = valid && ready && (left == 3'd1);

  // Load a new response or shift one byte out per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      left  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sh    <= word;
      left  <= count;
      valid <= (count != 3'd0);
    end else if (valid && ready) begin
      sh    <= {8'h00, sh[DATA_W-1:8]};
      left  <= left - 3'd1;
      valid <= (left != 3'd1);
    end
  end

endmodule

// File: rtl/sram_byte_bridge.sv
// Byte-framed command bridge onto a 1024x32 SRAM macro port.
// Frame: header, address low byte, then four data bytes for writes.
module sram_byte_bridge
  import sram_bridge_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter bit WRITE_ACK    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_byte_bridge_if.slave bus,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_bm_o,
  output logic [DATA_W-1:0] sram_din_o,
  output logic              sram_wen_o,
  output logic              sram_ren_o,
  output logic              sram_men_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  localparam logic [1:0] LAT_LAST =
    2'(READ_LATENCY - 1);

  state_t      state;
  logic        cmd_ready;
  logic        acc;
  logic        hdr_wr;
  logic [3:0]  hdr_bm;
  logic [1:0]  hdr_ahi;
  logic [7:0]  addr_lo;
  logic [23:0] wbuf;
  logic [1:0]  bcnt;
  logic [1:0]  wcnt;

  logic              ser_load;
  logic              ser_done;
  logic [DATA_W-1:0] ser_word;
  logic [2:0]        ser_count;
  logic [7:0]        rsp_data;
  logic              rsp_valid;

  assign acc             = bus.cmd_valid_i && cmd_ready;
  assign bus.cmd_ready_o = cmd_ready;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_valid_o = rsp_valid;

  // The ack is loaded during the WEN cycle; read data is
  // loaded on the edge where the macro output is valid.
  always_comb begin
    ser_load  = 1'b0;
    ser_word  = sram_dout_i;
    ser_count = 3'd4;
    if (state == S_WRITE) begin
      ser_load  = WRITE_ACK;
      ser_word  = {24'h0, ACK_BYTE};
      ser_count = 3'd1;
    end else if (state == S_RWAIT) begin
      ser_load = (wcnt == LAT_LAST);
    end
  end

  // Frame FSM with registered SRAM port and cmd_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HDR;
      cmd_ready   <= 1'b0;
      hdr_wr      <= 1'b0;
      hdr_bm      <= '0;
      hdr_ahi     <= '0;
      addr_lo     <= '0;
      wbuf        <= '0;
      bcnt        <= '0;
      wcnt        <= '0;
      sram_addr_o <= '0;
      sram_bm_o   <= '0;
      sram_din_o  <= '0;
      sram_wen_o  <= 1'b0;
      sram_ren_o  <= 1'b0;
      sram_men_o  <= 1'b0;
    end else begin
      sram_wen_o <= 1'b0;
      sram_ren_o <= 1'b0;
      sram_men_o <= 1'b0;
      unique case (state)
        S_HDR: begin
          cmd_ready <= 1'b1;
          if (acc) begin
            hdr_wr  <= bus.cmd_data_i[HDR_WR];
            hdr_bm  <= bus.cmd_data_i[HDR_BM_HI:HDR_BM_LO];
            hdr_ahi <= bus.cmd_data_i[HDR_AHI_HI:0];
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (acc && hdr_wr) begin
            addr_lo <= bus.cmd_data_i;
            bcnt    <= '0;
            state   <= S_WDATA;
          end else if (acc) begin
            cmd_ready   <= 1'b0;
            sram_ren_o  <= 1'b1;
            sram_men_o  <= 1'b1;
            sram_addr_o <= {hdr_ahi, bus.cmd_data_i};
            sram_bm_o   <= bm_expand(hdr_bm);
            state       <= S_READ;
          end
        end
        S_WDATA: begin
          if (acc) begin
            wbuf <= {bus.cmd_data_i, wbuf[23:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              cmd_ready   <= 1'b0;
              sram_wen_o  <= 1'b1;
              sram_men_o  <= 1'b1;
              sram_addr_o <= {hdr_ahi, addr_lo};
              sram_bm_o   <= bm_expand(hdr_bm);
              sram_din_o  <= {bus.cmd_data_i, wbuf};
              state       <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (WRITE_ACK) begin
            state <= S_ACK;
          end else begin
            cmd_ready <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_READ: begin
          wcnt  <= '0;
          state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (wcnt == LAT_LAST) begin
            state <= S_RSP;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        S_ACK, S_RSP: begin
          if (ser_done) begin
            cmd_ready <= 1'b1;
            state     <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

  sram_bridge_rsp_ser u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .word  (ser_word),
    .count (ser_count),
    .data  (rsp_data),
    .valid (rsp_valid),
    .ready (bus.rsp_ready_i),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Bench for sram_byte_bridge: three builds (default, READ_LATENCY=3,
// WRITE_ACK=0) against a behavioural SRAM with latency and garbage dout.
module tb_sram_byte_bridge;

  typedef struct {
    logic        wr;
    logic [3:0]  m;
    logic        rsv;
    logic [9:0]  addr;
    logic [31:0] data;
    int          stall;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  cmd_data [3];
  logic        cmd_valid[3];
  logic        cmd_ready[3];
  logic [7:0]  rsp_data [3];
  logic        rsp_valid[3];
  logic        rsp_ready[3];
  logic [9:0]  s_addr   [3];
  logic [31:0] s_bm     [3];
  logic [31:0] s_din    [3];
  logic [31:0] s_dout   [3];
  logic        s_wen    [3];
  logic        s_ren    [3];
  logic        s_men    [3];

  sram_byte_bridge_if i0 ();
  sram_byte_bridge_if i1 ();
  sram_byte_bridge_if i2 ();

  assign i0.cmd_data_i  = cmd_data[0];
  assign i0.cmd_valid_i = cmd_valid[0];
  assign i0.rsp_ready_i = rsp_ready[0];
  assign cmd_ready[0]   = i0.cmd_ready_o;
  assign rsp_data[0]    = i0.rsp_data_o;
  assign rsp_valid[0]   = i0.rsp_valid_o;
  assign i1.cmd_data_i  = cmd_data[1];
  assign i1.cmd_valid_i = cmd_valid[1];
  assign i1.rsp_ready_i = rsp_ready[1];
  assign cmd_ready[1]   = i1.cmd_ready_o;
  assign rsp_data[1]    = i1.rsp_data_o;
  assign rsp_valid[1]   = i1.rsp_valid_o;
  assign i2.cmd_data_i  = cmd_data[2];
  assign i2.cmd_valid_i = cmd_valid[2];
  assign i2.rsp_ready_i = rsp_ready[2];
  assign cmd_ready[2]   = i2.cmd_ready_o;
  assign rsp_data[2]    = i2.rsp_data_o;
  assign rsp_valid[2]   = i2.rsp_valid_o;

  sram_byte_bridge #(.READ_LATENCY(1), .WRITE_ACK(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(i0.slave),
    .sram_addr_o(s_addr[0]), .sram_bm_o(s_bm[0]),
    .sram_din_o(s_din[0]), .sram_wen_o(s_wen[0]),
    .sram_ren_o(s_ren[0]), .sram_men_o(s_men[0]),
    .sram_dout_i(s_dout[0])
  );

  sram_byte_bridge #(.READ_LATENCY(3), .WRITE_ACK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(i1.slave),
    .sram_addr_o(s_addr[1]), .sram_bm_o(s_bm[1]),
    .sram_din_o(s_din[1]), .sram_wen_o(s_wen[1]),
    .sram_ren_o(s_ren[1]), .sram_men_o(s_men[1]),
    .sram_dout_i(s_dout[1])
  );

  sram_byte_bridge #(.READ_LATENCY(1), .WRITE_ACK(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(i2.slave),
    .sram_addr_o(s_addr[2]), .sram_bm_o(s_bm[2]),
    .sram_din_o(s_din[2]), .sram_wen_o(s_wen[2]),
    .sram_ren_o(s_ren[2]), .sram_men_o(s_men[2]),
    .sram_dout_i(s_dout[2])
  );

  function automatic int rl(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  // SRAM model: masked write, READ_LATENCY pipeline, garbage when not valid.
  logic [31:0] mem [3][1024];
  logic        pv  [3][4];
  logic [31:0] pd  [3][4];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (s_men[k] && s_wen[k])
        mem[k][s_addr[k]] <= (mem[k][s_addr[k]] & ~s_bm[k]) | (s_din[k] & s_bm[k]);
      pv[k][0] <= s_men[k] && s_ren[k];
      pd[k][0] <= mem[k][s_addr[k]];
      for (int j = 1; j < 4; j++) begin
        pv[k][j] <= pv[k][j-1];
        pd[k][j] <= pd[k][j-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++)
      s_dout[k] = pv[k][rl(k)-1] ? pd[k][rl(k)-1] : 32'hDEAD_BEEF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle.
  int          acc_cyc [3];
  int          wen_cyc [3];
  int          ren_cyc [3];
  int          rise_cyc[3];
  int          wen_cnt [3];
  int          rv_cnt  [3];
  int          excl_bad[3];
  int          hold_bad[3];
  logic [9:0]  wen_addr[3];
  logic [31:0] wen_bm  [3];
  logic [31:0] wen_din [3];
  logic        prev_v  [3];
  logic        prev_r  [3];
  logic [7:0]  prev_d  [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      acc_cyc[k] = 0; wen_cyc[k] = 0; ren_cyc[k] = 0;
      rise_cyc[k] = 0; wen_cnt[k] = 0; rv_cnt[k] = 0;
      excl_bad[k] = 0; hold_bad[k] = 0;
      prev_v[k] = 0; prev_r[k] = 0; prev_d[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cmd_valid[k] && cmd_ready[k]) acc_cyc[k] = cyc;
      if (s_wen[k]) begin
        wen_cnt[k]++;
        wen_cyc[k]  = cyc;
        wen_addr[k] = s_addr[k];
        wen_bm[k]   = s_bm[k];
        wen_din[k]  = s_din[k];
      end
      if (s_ren[k]) ren_cyc[k] = cyc;
      if ((s_wen[k] && s_ren[k]) || (s_men[k] !== (s_wen[k] | s_ren[k])))
        excl_bad[k]++;
      if (rsp_valid[k] && !prev_v[k]) rise_cyc[k] = cyc;
      if (rsp_valid[k]) rv_cnt[k]++;
      if (prev_v[k] && !prev_r[k] && (!rsp_valid[k] || rsp_data[k] !== prev_d[k]))
        hold_bad[k]++;
      prev_v[k] = rsp_valid[k];
      prev_r[k] = rsp_ready[k];
      prev_d[k] = rsp_data[k];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int k, input string nm);
    chk({nm, "_cmdrdy"}, {31'h0, cmd_ready[k]}, 32'h0);
    chk({nm, "_rsp"}, {23'h0, rsp_valid[k], rsp_data[k]}, 32'h0);
    chk({nm, "_sram"},
        {31'h0, |{s_addr[k], s_bm[k], s_din[k], s_wen[k], s_ren[k], s_men[k]}},
        32'h0);
  endtask

  task automatic send_byte(input int k, input logic [7:0] b);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    cmd_data[k]  = b;
    cmd_valid[k] = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (cmd_ready[k]) ok = 1;
      else n++;
    end
    if (!ok) chk("cmd_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    cmd_valid[k] = 1'b0;
  endtask

  task automatic get_rsp(input int k, input int stall, output logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    b  = 8'hxx;
    rsp_ready[k] = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    rsp_ready[k] = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (rsp_valid[k]) begin
        ok = 1;
        b  = rsp_data[k];
      end else n++;
    end
    if (!ok) chk("rsp_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    rsp_ready[k] = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [7:0]  b;
    logic [31:0] word;
    int          t;
    int          w0;
    w0 = wen_cnt[k];
    send_byte(k, {v.wr, v.m, v.rsv, v.addr[9:8]});
    send_byte(k, v.addr[7:0]);
    if (v.wr) begin
      for (int i = 0; i < 4; i++) send_byte(k, v.data[8*i +: 8]);
      t = acc_cyc[k];
      get_rsp(k, v.stall, b);
      chk("ack_byte", {24'h0, b}, 32'h5A);
      chk("ack_lat", rise_cyc[k] - t, 2);
      chk("wen_cnt", wen_cnt[k], w0 + 1);
      chk("wen_lat", wen_cyc[k] - t, 1);
      chk("wen_addr", {22'h0, wen_addr[k]}, {22'h0, v.addr});
      chk("wen_bm", wen_bm[k], v.exp);
      chk("wen_din", wen_din[k], v.data);
    end else begin
      t = acc_cyc[k];
      word = 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (i == 3) chk("busy_rdy", {31'h0, cmd_ready[k]}, 32'h0);
        get_rsp(k, (i % 2 == 1) ? v.stall : 0, b);
        word[8*i +: 8] = b;
      end
      chk("rd_done_rdy", {31'h0, cmd_ready[k]}, 32'h1);
      chk("ren_lat", ren_cyc[k] - t, 1);
      chk("rd_lat", rise_cyc[k] - t, 2 + rl(k));
      chk("rd_data", word, v.exp);
      chk("rd_nowen", wen_cnt[k], w0);
    end
  endtask

  vec_t tab[12];
  vec_t post[2];
  vec_t lat3[2];

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int t1;
    int t2;
    int t3;
    int w0;

    tab[0]  = '{1'b1, 4'hF, 1'b0, 10'h123, 32'h12345678, 0, 32'hFFFF_FFFF};
    tab[1]  = '{1'b0, 4'h0, 1'b0, 10'h123, 32'h0,        0, 32'h12345678};
    tab[2]  = '{1'b1, 4'hF, 1'b0, 10'h3FF, 32'h12345678, 1, 32'hFFFF_FFFF};
    tab[3]  = '{1'b1, 4'h1, 1'b0, 10'h3FF, 32'hDDCCBBAA, 0, 32'h0000_00FF};
    tab[4]  = '{1'b0, 4'h0, 1'b0, 10'h3FF, 32'h0,        2, 32'h123456AA};
    tab[5]  = '{1'b1, 4'hF, 1'b1, 10'h000, 32'hA5A5A5A5, 0, 32'hFFFF_FFFF};
    tab[6]  = '{1'b1, 4'h0, 1'b0, 10'h000, 32'hFFFFFFFF, 2, 32'h0000_0000};
    tab[7]  = '{1'b0, 4'h0, 1'b1, 10'h000, 32'h0,        1, 32'hA5A5A5A5};
    tab[8]  = '{1'b1, 4'hF, 1'b0, 10'h2AA, 32'hCAFEBABE, 0, 32'hFFFF_FFFF};
    tab[9]  = '{1'b1, 4'hA, 1'b0, 10'h2AA, 32'h11223344, 0, 32'hFF00_FF00};
    tab[10] = '{1'b0, 4'h0, 1'b0, 10'h2AA, 32'h0,        2, 32'h11FE33BE};
    tab[11] = '{1'b0, 4'hF, 1'b0, 10'h123, 32'h0,        0, 32'h12345678};
    post[0] = '{1'b1, 4'hF, 1'b0, 10'h155, 32'h0BADF00D, 0, 32'hFFFF_FFFF};
    post[1] = '{1'b0, 4'h0, 1'b0, 10'h155, 32'h0,        1, 32'h0BADF00D};
    lat3[0] = '{1'b1, 4'hF, 1'b0, 10'h000, 32'h87654321, 0, 32'hFFFF_FFFF};
    lat3[1] = '{1'b0, 4'h0, 1'b0, 10'h000, 32'h0,        1, 32'h87654321};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmd_data[k]  = 8'h00;
      cmd_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk("rdy_pre", {31'h0, cmd_ready[0]}, 32'h0);
    @(negedge clk);
    chk("rdy_post", {31'h0, cmd_ready[0]}, 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(0, tab[i]);

    w0 = wen_cnt[0];
    send_byte(0, 8'hF9);
    send_byte(0, 8'h55);
    send_byte(0, 8'h01);
    send_byte(0, 8'h02);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_nowen", wen_cnt[0], w0);
    for (int i = 0; i < 2; i++) run_vec(0, post[i]);

    for (int i = 0; i < 2; i++) run_vec(1, lat3[i]);

    send_byte(2, 8'hF8);
    send_byte(2, 8'h10);
    send_byte(2, 8'h44);
    send_byte(2, 8'h33);
    send_byte(2, 8'h22);
    send_byte(2, 8'h11);
    t1 = acc_cyc[2];
    send_byte(2, 8'hF8);
    t2 = acc_cyc[2];
    chk("b2b_wen", wen_cyc[2] - t1, 1);
    chk("b2b_hdr", t2 - t1, 2);
    chk("b2b_din0", wen_din[2], 32'h11223344);
    send_byte(2, 8'h11);
    send_byte(2, 8'h88);
    send_byte(2, 8'h77);
    send_byte(2, 8'h66);
    send_byte(2, 8'h55);
    t3 = acc_cyc[2];
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_wen_cnt", wen_cnt[2], 2);
    chk("b2b_wen_lat", wen_cyc[2] - t3, 1);
    chk("b2b_addr", {22'h0, wen_addr[2]}, 32'h011);
    chk("b2b_din1", wen_din[2], 32'h55667788);
    chk("noack_rsp", rv_cnt[2], 0);
    chk("noack_rdy", {31'h0, cmd_ready[2]}, 32'h1);

    for (int k = 0; k < 3; k++) begin
      chk("excl", excl_bad[k], 0);
      chk("hold", hold_bad[k], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
